ttt_turn_arbiter: RTL and testbench
===================================

Name: ttt_turn_arbiter

Overview:
- Sequences a two-player tic-tac-toe game against the board engine.
- The engine holds 9 cells, 2 bits each: 00 empty, 01 player 0 (X), 10 player 1 (O). Its winner code is 01/10, 11 = draw.
- Arbitrates between two move requesters (P0, P1), enforces turn order, pre-validates moves against the board, issues a single-cycle move strobe, waits for engine settle, then reports game result.
- Adds an optional per-turn timeout with forfeit.

Parameters:
- FIRST_PLAYER, 0, player that owns the first turn after start.
- TIMEOUT_CYCLES, 0, cycles a player may idle in its turn before forfeiting; 0 disables the timeout.
- TW, 16, width of the timeout counter; TIMEOUT_CYCLES must be < 2^TW.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  pulse; begins a new game from DONE or IDLE
- req0  in  1  P0 move request; held until ack0 or nack0
- pos0  in  4  P0 requested cell 0..8
- req1  in  1  P1 move request; held until ack1 or nack1
- pos1  in  4  P1 requested cell 0..8
- ack0, ack1  out  1  one-cycle pulse: move accepted and committed
- nack0, nack1  out  1  one-cycle pulse: move rejected; err_code valid same cycle
- err_code  out  2  00 none, 01 not your turn, 10 position >8, 11 cell occupied
- eng_board  in  18  engine board; cell i at bits [2i+1:2i]
- eng_game_over  in  1  engine game-over flag
- eng_winner  in  2  engine winner code
- eng_reset  out  1  synchronous clear request to engine (one-cycle pulse)
- mv_valid  out  1  move strobe to engine, one cycle
- mv_player  out  1  player for mv_valid
- mv_pos  out  4  position for mv_valid
- turn  out  1  player whose turn it is
- move_count  out  4  committed moves in current game, 0..9
- done  out  1  high while in DONE
- result  out  2  00 none, 01 P0 won, 10 P1 won, 11 draw
- forfeit  out  1  high in DONE if the game ended by timeout

Behaviour:
- Reset (async): state IDLE. All pulses 0. turn=FIRST_PLAYER, move_count=0, result=00, done=0, forfeit=0, err_code=00, mv_pos=0, mv_player=0.
- FSM states: IDLE, CLEAR, WAIT, CHECK, ISSUE, SETTLE1, SETTLE2, DONE.
- IDLE/DONE + start: go to CLEAR and pulse eng_reset. Clear move_count, result, forfeit; set turn=FIRST_PLAYER. start is ignored in other states.
- CLEAR: one cycle, then WAIT.
- WAIT:
  - Request of the non-turn player: nack for that player next cycle with err 01. Stay in WAIT. The timeout counter is not reset.
  - Request of the turn player: latch its position, go to CHECK.
  - Both requesting in the same cycle: the turn player wins; the other is nacked with 01 in the same cycle.
- CHECK:
  - pos >8: nack, err 10, back to WAIT.
  - eng_board cell != 00: nack, err 11, back to WAIT.
  - Otherwise go to ISSUE.
- ISSUE: mv_valid=1 for exactly one cycle with mv_player=turn and mv_pos=latched position; then SETTLE1.
- SETTLE1/SETTLE2: two wait cycles so the engine's registered win check completes.
- End of SETTLE2:
  - Pulse ack for the mover and increment move_count.
  - If eng_game_over: result=eng_winner, go to DONE.
  - Else toggle turn and go to WAIT.
- Latency: accepted request to ack = 5 cycles (WAIT, CHECK, ISSUE, SETTLE1, SETTLE2; ack is registered in the cycle after SETTLE2).
- Timeout:
  - Counter clears on entry to WAIT with a new turn, and counts each cycle in WAIT.
  - When TIMEOUT_CYCLES≠0 and the count reaches TIMEOUT_CYCLES: result = opponent code, forfeit=1, go to DONE.
  - A request arriving in the same cycle as the timeout is nacked with err 01.
- Requests seen in IDLE, CLEAR or DONE are nacked with err 01.
- The requester must hold req/pos stable until ack or nack. A request dropped mid-check is still processed.
- move_count saturates at 9. The draw code comes from the engine only.
- Reset mid-game: immediate return to IDLE. The engine is reset by the same system reset.

Decomposition:
- Shared package ttt_pkg:
  - cell codes EMPTY/X/O
  - result codes NONE/P0/P1/DRAW
  - err codes
  - FSM state enum
  - constant NCELLS=9
- Sub-module ttt_turn_timer: loadable counter with enable, clear and expire output. It is reused for later round timers.

Test Plan:
- Reset, start; P0 plays 0, P1 3, P0 1, P1 4, P0 2 -> five acks each 5 cycles after request; result=01, done=1, move_count=5, forfeit=0.
- P1 requests while turn=0 -> nack1 with err_code=01; turn stays 0; no mv_valid issued.
- P0 requests pos 9 -> nack0 err 10. P0 requests an occupied cell 4 -> nack0 err 11. No mv_valid in either case.
- Full 9-move draw sequence (X:0,2,3,7,8 O:1,4,5,6 interleaved) -> result=11, move_count=9, done=1.
- TIMEOUT_CYCLES=20: after start, P0 never requests -> at WAIT cycle 20, done=1, result=10, forfeit=1.
- Async reset asserted during SETTLE1 -> outputs return to reset values immediately. Next start gives a fresh game with turn=FIRST_PLAYER.

Source files
------------

// File: rtl/ttt_pkg.sv
// Shared codes, FSM states and board helpers for the tic-tac-toe turn arbiter.
package ttt_pkg;

    localparam int NCELLS = 9;

    typedef enum logic [1:0] {
        CELL_EMPTY = 2'b00,
        CELL_X     = 2'b01,
        CELL_O     = 2'b10
    } cell_t;

    typedef enum logic [1:0] {
        RES_NONE = 2'b00,
        RES_P0   = 2'b01,
        RES_P1   = 2'b10,
        RES_DRAW = 2'b11
    } result_t;

    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_TURN = 2'b01,
        ERR_POS  = 2'b10,
        ERR_OCC  = 2'b11
    } err_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_WAIT,
        ST_CHECK,
        ST_ISSUE,
        ST_SETTLE1,
        ST_SETTLE2,
        ST_DONE
    } state_t;

    // Out-of-range positions read as empty; the caller rejects them separately.
    function automatic cell_t cell_at(input logic [2*NCELLS-1:0] board, input logic [3:0] pos);
        cell_t c;
        c = CELL_EMPTY;
        for (int i = 0; i < NCELLS; i++) begin
            if (pos == 4'(i)) begin
                c = cell_t'(board[2*i +: 2]);
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/ttt_turn_timer.sv
// Loadable up-counter with enable/clear; expire flags the cycle in which the count reaches the limit.
module ttt_turn_timer
    import ttt_pkg::*;
#(
    parameter int TW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_clear,
    input  logic          i_load,
    input  logic [TW-1:0] i_load_value,
    input  logic          i_en,
    input  logic [TW-1:0] i_limit,
    output logic          o_expire
);

    logic [TW-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_value;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + TW'(1);
        end
    end

    // A zero limit disables expiry altogether.
    assign o_expire = i_en && (i_limit != '0) &&
                      (({1'b0, r_count} + (TW+1)'(1)) == {1'b0, i_limit});

endmodule

// File: rtl/ttt_turn_arbiter.sv
// Two-player turn arbiter: validates requests against the engine board, strobes moves, reports results.
module ttt_turn_arbiter
    import ttt_pkg::*;
#(
    parameter int FIRST_PLAYER   = 0,
    parameter int TIMEOUT_CYCLES = 0,
    parameter int TW             = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        req0,
    input  logic [3:0]  pos0,
    input  logic        req1,
    input  logic [3:0]  pos1,
    output logic        ack0,
    output logic        ack1,
    output logic        nack0,
    output logic        nack1,
    output logic [1:0]  err_code,
    input  logic [17:0] eng_board,
    input  logic        eng_game_over,
    input  logic [1:0]  eng_winner,
    output logic        eng_reset,
    output logic        mv_valid,
    output logic        mv_player,
    output logic [3:0]  mv_pos,
    output logic        turn,
    output logic [3:0]  move_count,
    output logic        done,
    output logic [1:0]  result,
    output logic        forfeit
);

    localparam logic FIRST = 1'(FIRST_PLAYER);

    state_t     r_state, w_state_next;
    logic       r_turn, w_turn_next;
    logic [3:0] r_pos, w_pos_next;
    logic [3:0] r_move_count, w_move_count_next;
    result_t    r_result, w_result_next;
    logic       r_forfeit, w_forfeit_next;
    logic       r_ack0, w_ack0_next, r_ack1, w_ack1_next;
    logic       r_nack0, w_nack0_next, r_nack1, w_nack1_next;
    err_t       r_err, w_err_next;
    logic       r_mv_valid, w_mv_valid_next;
    logic       r_mv_player, w_mv_player_next;
    logic [3:0] r_mv_pos, w_mv_pos_next;
    logic       r_eng_reset, w_eng_reset_next;

    logic       w_req_turn, w_req_other, w_expire, w_tmr_clear;
    logic [3:0] w_pos_turn;

    assign w_req_turn  = r_turn ? req1 : req0;
    assign w_req_other = r_turn ? req0 : req1;
    assign w_pos_turn  = r_turn ? pos1 : pos0;

    // The timer restarts whenever WAIT is entered for a fresh turn, not after a rejected move.
    assign w_tmr_clear = (r_state == ST_CLEAR) || ((r_state == ST_SETTLE2) && !eng_game_over);

    ttt_turn_timer #(.TW(TW)) u_timer (
        .clk          (clk),
        .reset        (reset),
        .i_clear      (w_tmr_clear),
        .i_load       (1'b0),
        .i_load_value ('0),
        .i_en         (r_state == ST_WAIT),
        .i_limit      (TW'(TIMEOUT_CYCLES)),
        .o_expire     (w_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_turn       <= FIRST;
            r_pos        <= '0;
            r_move_count <= '0;
            r_result     <= RES_NONE;
            r_forfeit    <= 1'b0;
            r_ack0       <= 1'b0;
            r_ack1       <= 1'b0;
            r_nack0      <= 1'b0;
            r_nack1      <= 1'b0;
            r_err        <= ERR_NONE;
            r_mv_valid   <= 1'b0;
            r_mv_player  <= 1'b0;
            r_mv_pos     <= '0;
            r_eng_reset  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_turn       <= w_turn_next;
            r_pos        <= w_pos_next;
            r_move_count <= w_move_count_next;
            r_result     <= w_result_next;
            r_forfeit    <= w_forfeit_next;
            r_ack0       <= w_ack0_next;
            r_ack1       <= w_ack1_next;
            r_nack0      <= w_nack0_next;
            r_nack1      <= w_nack1_next;
            r_err        <= w_err_next;
            r_mv_valid   <= w_mv_valid_next;
            r_mv_player  <= w_mv_player_next;
            r_mv_pos     <= w_mv_pos_next;
            r_eng_reset  <= w_eng_reset_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_turn_next       = r_turn;
        w_pos_next        = r_pos;
        w_move_count_next = r_move_count;
        w_result_next     = r_result;
        w_forfeit_next    = r_forfeit;
        w_ack0_next       = 1'b0;
        w_ack1_next       = 1'b0;
        w_nack0_next      = 1'b0;
        w_nack1_next      = 1'b0;
        w_err_next        = ERR_NONE;
        w_mv_valid_next   = 1'b0;
        w_mv_player_next  = r_mv_player;
        w_mv_pos_next     = r_mv_pos;
        w_eng_reset_next  = 1'b0;

        case (r_state)
            ST_IDLE, ST_DONE: begin
                w_nack0_next = req0;
                w_nack1_next = req1;
                if (req0 || req1) w_err_next = ERR_TURN;
                if (start) begin
                    w_state_next      = ST_CLEAR;
                    w_eng_reset_next  = 1'b1;
                    w_move_count_next = '0;
                    w_result_next     = RES_NONE;
                    w_forfeit_next    = 1'b0;
                    w_turn_next       = FIRST;
                end
            end
            ST_CLEAR: w_state_next = ST_WAIT;
            ST_WAIT: begin
                if (w_expire) begin
                    // A request racing the timeout loses: the turn is already forfeited.
                    w_nack0_next   = req0;
                    w_nack1_next   = req1;
                    if (req0 || req1) w_err_next = ERR_TURN;
                    w_result_next  = r_turn ? RES_P0 : RES_P1;
                    w_forfeit_next = 1'b1;
                    w_state_next   = ST_DONE;
                end else begin
                    if (w_req_turn) begin
                        w_pos_next   = w_pos_turn;
                        w_state_next = ST_CHECK;
                    end
                    if (w_req_other) begin
                        w_nack0_next = r_turn;
                        w_nack1_next = !r_turn;
                        w_err_next   = ERR_TURN;
                    end
                end
            end
            ST_CHECK: begin
                if ((r_pos > 4'd8) || (cell_at(eng_board, r_pos) != CELL_EMPTY)) begin
                    w_nack0_next = !r_turn;
                    w_nack1_next = r_turn;
                    w_err_next   = (r_pos > 4'd8) ? ERR_POS : ERR_OCC;
                    w_state_next = ST_WAIT;
                end else begin
                    w_mv_valid_next  = 1'b1;
                    w_mv_player_next = r_turn;
                    w_mv_pos_next    = r_pos;
                    w_state_next     = ST_ISSUE;
                end
            end
            ST_ISSUE:   w_state_next = ST_SETTLE1;
            ST_SETTLE1: w_state_next = ST_SETTLE2;
            ST_SETTLE2: begin
                w_ack0_next       = !r_turn;
                w_ack1_next       = r_turn;
                w_move_count_next = (r_move_count == 4'd9) ? 4'd9 : r_move_count + 4'd1;
                if (eng_game_over) begin
                    w_result_next = result_t'(eng_winner);
                    w_state_next  = ST_DONE;
                end else begin
                    w_turn_next  = !r_turn;
                    w_state_next = ST_WAIT;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign ack0       = r_ack0;
    assign ack1       = r_ack1;
    assign nack0      = r_nack0;
    assign nack1      = r_nack1;
    assign err_code   = r_err;
    assign eng_reset  = r_eng_reset;
    assign mv_valid   = r_mv_valid;
    assign mv_player  = r_mv_player;
    assign mv_pos     = r_mv_pos;
    assign turn       = r_turn;
    assign move_count = r_move_count;
    assign done       = (r_state == ST_DONE);
    assign result     = r_result;
    assign forfeit    = r_forfeit;

endmodule

// File: tb/tb_ttt_turn_arbiter.sv
// Directed bench for ttt_turn_arbiter with a small registered board-engine model.
module tb_ttt_turn_arbiter;

    logic        clk = 1'b0;
    logic        reset, start;
    logic        req0, req1;
    logic [3:0]  pos0, pos1;
    logic        ack0, ack1, nack0, nack1;
    logic [1:0]  err_code;
    logic [17:0] eng_board;
    logic        eng_game_over;
    logic [1:0]  eng_winner;
    logic        eng_reset, mv_valid, mv_player;
    logic [3:0]  mv_pos;
    logic        turn;
    logic [3:0]  move_count;
    logic        done, forfeit;
    logic [1:0]  result;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    ttt_turn_arbiter #(
        .FIRST_PLAYER   (0),
        .TIMEOUT_CYCLES (20),
        .TW             (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .req0          (req0),
        .pos0          (pos0),
        .req1          (req1),
        .pos1          (pos1),
        .ack0          (ack0),
        .ack1          (ack1),
        .nack0         (nack0),
        .nack1         (nack1),
        .err_code      (err_code),
        .eng_board     (eng_board),
        .eng_game_over (eng_game_over),
        .eng_winner    (eng_winner),
        .eng_reset     (eng_reset),
        .mv_valid      (mv_valid),
        .mv_player     (mv_player),
        .mv_pos        (mv_pos),
        .turn          (turn),
        .move_count    (move_count),
        .done          (done),
        .result        (result),
        .forfeit       (forfeit)
    );

    // Win/draw evaluation of a board: {game_over, winner}.
    function automatic logic [2:0] eval_board(input logic [17:0] b);
        int ln [8][3];
        logic [1:0] c0, c1, c2;
        logic [2:0] r;
        bit full;
        ln = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
        r = 3'b000;
        for (int l = 0; l < 8; l++) begin
            c0 = b[2*ln[l][0] +: 2];
            c1 = b[2*ln[l][1] +: 2];
            c2 = b[2*ln[l][2] +: 2];
            if (c0 != 2'b00 && c0 == c1 && c1 == c2) r = {1'b1, c0};
        end
        if (r == 3'b000) begin
            full = 1'b1;
            for (int i = 0; i < 9; i++) if (b[2*i +: 2] == 2'b00) full = 1'b0;
            if (full) r = 3'b111;
        end
        return r;
    endfunction

    // Engine model: board written on mv_valid, win check registered one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            eng_board     <= '0;
            eng_game_over <= 1'b0;
            eng_winner    <= 2'b00;
        end else if (eng_reset) begin
            eng_board     <= '0;
            eng_game_over <= 1'b0;
            eng_winner    <= 2'b00;
        end else begin
            if (mv_valid) eng_board[2*mv_pos +: 2] <= mv_player ? 2'b10 : 2'b01;
            {eng_game_over, eng_winner} <= eval_board(eng_board);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic drive_req(input bit p, input logic [3:0] pos, input bit val);
        if (p) begin req1 = val; pos1 = pos; end
        else   begin req0 = val; pos0 = pos; end
    endtask

    task automatic start_game();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("start_eng_reset", int'(eng_reset), 1);
        @(posedge clk); #1;
        chk("clear_eng_reset_drop", int'(eng_reset), 0);
        chk("start_turn", int'(turn), 0);
        chk("start_move_count", int'(move_count), 0);
        $display("start game");
    endtask

    task automatic play(input bit p, input logic [3:0] pos);
        int n, mv_hits;
        bit got_ack, got_nack;
        n = 0; mv_hits = 0; got_ack = 0; got_nack = 0;
        drive_req(p, pos, 1'b1);
        while (!got_ack && !got_nack && n < 20) begin
            @(posedge clk); #1;
            n++;
            if (mv_valid && mv_pos == pos && mv_player == p) mv_hits++;
            got_ack  = p ? ack1 : ack0;
            got_nack = p ? nack1 : nack0;
        end
        drive_req(p, 4'd0, 1'b0);
        chk($sformatf("move_p%0d_pos%0d_ack_lat", p, pos), got_ack ? n : -1, 5);
        chk($sformatf("move_p%0d_pos%0d_mv", p, pos), mv_hits, 1);
        $display("move p=%0d pos=%0d latency=%0d count=%0d", p, pos, n, move_count);
    endtask

    task automatic reject(input bit p, input logic [3:0] pos, input int exp_err);
        int n, mv_hits;
        bit got_nack;
        n = 0; mv_hits = 0; got_nack = 0;
        drive_req(p, pos, 1'b1);
        while (!got_nack && n < 10) begin
            @(posedge clk); #1;
            n++;
            if (mv_valid) mv_hits++;
            got_nack = p ? nack1 : nack0;
        end
        chk($sformatf("nack_p%0d_pos%0d_seen", p, pos), int'(got_nack), 1);
        chk($sformatf("nack_p%0d_pos%0d_err", p, pos), int'(err_code), exp_err);
        chk($sformatf("nack_p%0d_pos%0d_no_mv", p, pos), mv_hits, 0);
        drive_req(p, 4'd0, 1'b0);
        $display("reject p=%0d pos=%0d err=%0d after=%0d", p, pos, err_code, n);
    endtask

    initial begin
        int n;
        reset = 1'b1; start = 1'b0;
        req0 = 1'b0; req1 = 1'b0; pos0 = '0; pos1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_turn", int'(turn), 0);
        chk("rst_move_count", int'(move_count), 0);
        chk("rst_mv_valid", int'(mv_valid), 0);
        chk("rst_err", int'(err_code), 0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Game 1: P0 wins on the top row.
        start_game();
        play(0, 4'd0); play(1, 4'd3); play(0, 4'd1); play(1, 4'd4); play(0, 4'd2);
        chk("g1_done", int'(done), 1);
        chk("g1_result", int'(result), 1);
        chk("g1_move_count", int'(move_count), 5);
        chk("g1_forfeit", int'(forfeit), 0);

        // Game 2: rejection paths, then reset during SETTLE1.
        start_game();
        reject(1, 4'd5, 1);
        chk("g2_turn_after_nack", int'(turn), 0);
        reject(0, 4'd9, 2);
        play(0, 4'd4);
        play(1, 4'd0);
        reject(0, 4'd4, 3);
        reject(0, 4'd0, 3);
        chk("g2_turn_kept", int'(turn), 0);
        chk("g2_count_before_rst", int'(move_count), 2);
        drive_req(0, 4'd8, 1'b1);
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_move_count", int'(move_count), 0);
        chk("midrst_turn", int'(turn), 0);
        chk("midrst_mv_pos", int'(mv_pos), 0);
        chk("midrst_ack0", int'(ack0), 0);
        chk("midrst_done", int'(done), 0);
        drive_req(0, 4'd0, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        $display("mid-game reset applied");

        // Game 3: nine-move draw.
        start_game();
        play(0, 4'd0); play(1, 4'd1); play(0, 4'd2); play(1, 4'd4); play(0, 4'd3);
        play(1, 4'd5); play(0, 4'd7); play(1, 4'd6); play(0, 4'd8);
        chk("g3_done", int'(done), 1);
        chk("g3_result", int'(result), 3);
        chk("g3_move_count", int'(move_count), 9);

        // Game 4: P0 idles until the turn timer forfeits it.
        start_game();
        n = 0;
        while (!done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("to_wait_cycles", n, 20);
        chk("to_result", int'(result), 2);
        chk("to_forfeit", int'(forfeit), 1);
        $display("timeout after %0d wait cycles result=%0d", n, result);
        reject(0, 4'd0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
